// File: rtl/test_cam_top_if.sv
`default_nettype none
// ============================================================================
//  Module      : test_cam_top_if
//  Description : Bundles the camera pins, VGA pins and frame-buffer debug
//                taps of test_cam_top into one interface.
//                master : drives camera inputs, observes everything else
//                slave  : the capture/display block itself
//  Ports       : CAM_pclk/CAM_vsync/CAM_href/CAM_px_data (camera -> block)
//                CAM_xclk/CAM_pwdn/CAM_reset            (block -> camera)
//                VGA_Hsync_n/VGA_Vsync_n/VGA_R/G/B      (block -> display)
//                data_mem/DP_RAM_addr_in/DP_RAM_data_in/DP_RAM_addr_out
//                                                       (buffer debug taps)
//  Revision    : 1.0  initial release
// ============================================================================
interface test_cam_top_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic          CAM_pclk;
  logic          CAM_vsync;
  logic          CAM_href;
  logic [7:0]    CAM_px_data;
  logic          CAM_xclk;
  logic          CAM_pwdn;
  logic          CAM_reset;
  logic          VGA_Hsync_n;
  logic          VGA_Vsync_n;
  logic [3:0]    VGA_R;
  logic [3:0]    VGA_G;
  logic [3:0]    VGA_B;
  logic [DW-1:0] data_mem;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;
  logic [AW-1:0] DP_RAM_addr_out;

  modport master (
    output CAM_pclk, CAM_vsync, CAM_href, CAM_px_data,
    input  CAM_xclk, CAM_pwdn, CAM_reset,
    input  VGA_Hsync_n, VGA_Vsync_n, VGA_R, VGA_G, VGA_B,
    input  data_mem, DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_addr_out
  );

  modport slave (
    input  CAM_pclk, CAM_vsync, CAM_href, CAM_px_data,
    output CAM_xclk, CAM_pwdn, CAM_reset,
    output VGA_Hsync_n, VGA_Vsync_n, VGA_R, VGA_G, VGA_B,
    output data_mem, DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_addr_out
  );
endinterface
`default_nettype wire

// File: rtl/test_cam_top.sv
`default_nettype none
// ============================================================================
//  Module      : test_cam_top
//  Description : OV7670 capture + VGA display. Camera RGB565 byte pairs are
//                converted to RGB444 and written into an IMG_W x IMG_H
//                dual-port frame buffer; the buffer is scanned out in the
//                top-left corner of a 640x480@60 VGA raster.
//  Ports       : clk  - 100 MHz system clock (only clock)
//                rst  - asynchronous active-low reset
//                bus  - test_cam_top_if.slave (camera, VGA, debug taps)
//  Revision    : 1.0  initial release
// ============================================================================
module test_cam_top #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input wire logic      clk,
  input wire logic      rst,
  test_cam_top_if.slave bus
);

  localparam int            DEPTH    = IMG_W * IMG_H;
  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;

  // --------------------------------------------------------------------------
  // Camera input synchronisers. Data and href go through the same two-flop
  // depth as pclk so the byte seen on pstrobe is the one sampled on the pclk
  // rising edge, not one that changed on the following falling edge.
  // --------------------------------------------------------------------------
  logic [1:0] pclk_sync_q;
  logic [1:0] vsync_sync_q;
  logic [1:0] href_sync_q;
  logic [7:0] data_sync1_q;
  logic [7:0] data_sync2_q;
  logic       pclk_prev_q;
  logic       vsync_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_sync_q  <= '0;
      vsync_sync_q <= '0;
      href_sync_q  <= '0;
      data_sync1_q <= '0;
      data_sync2_q <= '0;
      pclk_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      pclk_sync_q  <= {pclk_sync_q[0], bus.CAM_pclk};
      vsync_sync_q <= {vsync_sync_q[0], bus.CAM_vsync};
      href_sync_q  <= {href_sync_q[0], bus.CAM_href};
      data_sync1_q <= bus.CAM_px_data;
      data_sync2_q <= data_sync1_q;
      pclk_prev_q  <= pclk_sync_q[1];
      vsync_prev_q <= vsync_sync_q[1];
    end
  end

  logic pstrobe;
  logic vs_rise;
  logic vs_fall;
  logic href;

  assign pstrobe = pclk_sync_q[1] & ~pclk_prev_q;
  assign vs_rise = vsync_sync_q[1] & ~vsync_prev_q;
  assign vs_fall = ~vsync_sync_q[1] & vsync_prev_q;
  assign href    = href_sync_q[1];

  // --------------------------------------------------------------------------
  // Capture FSM. The assembled pixel is registered together with a write
  // strobe; the buffer write and the address increment both happen on the
  // following clock. Once the last address has been written the pointer
  // parks there and further writes are blocked until the next frame start.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    BYTE1      = 2'd1,
    BYTE2      = 2'd2
  } cap_state_t;

  cap_state_t    state_q;
  logic [6:0]    b1_q;        // first byte minus bit 3, which RGB444 drops
  logic          we_q;
  logic          full_q;
  logic [AW-1:0] addr_in_q;
  logic [DW-1:0] data_in_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WAIT_FRAME;
      b1_q      <= '0;
      we_q      <= 1'b0;
      full_q    <= 1'b0;
      addr_in_q <= '0;
      data_in_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (we_q && !full_q) begin
        if (addr_in_q == ADDR_MAX) full_q    <= 1'b1;
        else                       addr_in_q <= addr_in_q + 1'b1;
      end

      // A vsync rise overrides any pstrobe in the same cycle.
      if (vs_rise) begin
        state_q <= WAIT_FRAME;
      end else begin
        case (state_q)
          WAIT_FRAME: begin
            if (vs_fall) begin
              addr_in_q <= '0;
              full_q    <= 1'b0;
              state_q   <= BYTE1;
            end
          end
          BYTE1: begin
            if (pstrobe && href) begin
              b1_q    <= {data_sync2_q[7:4], data_sync2_q[2:0]};
              state_q <= BYTE2;
            end
          end
          BYTE2: begin
            if (!href) begin
              state_q <= BYTE1;  // line ended mid-pixel: drop the half pixel
            end else if (pstrobe) begin
              // RGB565 -> RGB444: R=b1[7:4], G={b1[2:0],b2[7]}, B=b2[4:1]
              data_in_q <= {b1_q, data_sync2_q[7], data_sync2_q[4:1]};
              we_q      <= 1'b1;
              state_q   <= BYTE1;
            end
          end
          default: state_q <= WAIT_FRAME;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame buffer. Not reset so a reset never loses the stored picture.
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] addr_out_q;
  logic [DW-1:0] data_mem_q;

  always_ff @(posedge clk) begin
    if (we_q && !full_q) mem[addr_in_q] <= data_in_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_mem_q <= '0;
    else      data_mem_q <= mem[addr_out_q];
  end

  // --------------------------------------------------------------------------
  // VGA raster. Stage 1 (on a pixel enable) issues the read address and
  // captures sync/blank for the current position; stage 2 (next pixel
  // enable) presents RGB and the matching sync, so sync and colour stay
  // aligned and a line is exactly 800 pixel enables long.
  // --------------------------------------------------------------------------
  logic [1:0]    div_q;
  logic [9:0]    h_q;
  logic [9:0]    v_q;
  logic          win1_q;
  logic          vis1_q;
  logic          hs1_q;
  logic          vs1_q;
  logic          hsync_q;
  logic          vsync_q;
  logic [11:0]   rgb_q;
  logic          pe;
  logic          in_win;
  logic          in_vis;
  logic [AW-1:0] addr_calc;

  assign pe        = (div_q == 2'd3);
  assign in_win    = (h_q < 10'(IMG_W)) && (v_q < 10'(IMG_H));
  assign in_vis    = (h_q < H_VIS) && (v_q < V_VIS);
  assign addr_calc = AW'(v_q) * AW'(IMG_W) + AW'(h_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      win1_q     <= 1'b0;
      vis1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      addr_out_q <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      rgb_q      <= '0;
    end else begin
      div_q <= div_q + 2'd1;
      if (pe) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          v_q <= (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end else begin
          h_q <= h_q + 10'd1;
        end
        win1_q <= in_win;
        vis1_q <= in_vis;
        hs1_q  <= !((h_q >= H_SYNC_S) && (h_q <= H_SYNC_E));
        vs1_q  <= !((v_q >= V_SYNC_S) && (v_q <= V_SYNC_E));
        if (in_win) addr_out_q <= addr_calc;
        hsync_q <= hs1_q;
        vsync_q <= vs1_q;
        rgb_q   <= (win1_q && vis1_q) ? data_mem_q : 12'd0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.CAM_xclk        = div_q[1];
  assign bus.CAM_pwdn        = 1'b0;
  assign bus.CAM_reset       = 1'b1;
  assign bus.VGA_Hsync_n     = hsync_q;
  assign bus.VGA_Vsync_n     = vsync_q;
  assign bus.VGA_R           = rgb_q[11:8];
  assign bus.VGA_G           = rgb_q[7:4];
  assign bus.VGA_B           = rgb_q[3:0];
  assign bus.data_mem        = data_mem_q;
  assign bus.DP_RAM_addr_in  = addr_in_q;
  assign bus.DP_RAM_data_in  = data_in_q;
  assign bus.DP_RAM_addr_out = addr_out_q;

endmodule
`default_nettype wire

// File: tb/tb_test_cam_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_cam_top
//  Description : Self-checking bench for test_cam_top using a reduced 16x8
//                image. Camera frames are generated from random bytes; a
//                reference model computes the stored RGB444 picture and the
//                expected write stream, and the VGA output is compared pixel
//                by pixel against the model picture.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_test_cam_top;

  localparam int W    = 16;
  localparam int H    = 8;
  localparam int AW   = 15;
  localparam int DW   = 12;
  localparam int MAXA = W * H - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  test_cam_top_if #(.AW(AW), .DW(DW)) bus ();

  test_cam_top #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [11:0] exp_mem [W*H];
  int          wq[$];          // expected writes: addr*4096 + pixel
  int          m_addr = 0;
  bit          m_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] rgb444(input logic [7:0] b1, input logic [7:0] b2);
    int r, g, b;
    r = int'(b1) / 16;
    g = (int'(b1) % 8) * 2 + int'(b2) / 128;
    b = (int'(b2) / 2) % 16;
    return 12'(r * 256 + g * 16 + b);
  endfunction

  task automatic model_pixel(input logic [7:0] b1, input logic [7:0] b2);
    logic [11:0] p;
    p = rgb444(b1, b2);
    if (!m_full) begin
      exp_mem[m_addr] = p;
      if (m_addr == MAXA) m_full = 1'b1;
      else begin
        wq.push_back(m_addr * 4096 + int'(p));
        m_addr++;
      end
    end
  endtask

  // one camera byte at pclk = clk/4; data changes with the pclk fall
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); bus.CAM_pclk = 1'b0; bus.CAM_px_data = b;
    @(negedge clk);
    @(negedge clk); bus.CAM_pclk = 1'b1;
    @(negedge clk);
  endtask

  // mode 0: random bytes, 1: all 0x0F, 2: first pair F8,1F then random
  task automatic send_line(input int nbytes, input int mode);
    logic [7:0] b, b1;
    b1 = 8'h00;
    @(negedge clk); bus.CAM_href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      if (mode == 1)               b = 8'h0F;
      else if (mode == 2 && i == 0) b = 8'hF8;
      else if (mode == 2 && i == 1) b = 8'h1F;
      else                          b = 8'($urandom);
      if (i % 2 == 1) model_pixel(b1, b);
      else            b1 = b;
      send_byte(b);
    end
    @(negedge clk); bus.CAM_href = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
  endtask

  task automatic capture();
    int k;
    repeat (40) @(negedge clk);
    bus.CAM_vsync = 1'b0;
    repeat (8) @(negedge clk);
    send_line(2 * W, 2);
    send_line(2 * W, 1);
    k = $urandom_range(0, W / 2 - 1);
    send_line(2 * k + 1, 0);            // odd byte count: trailing half pixel
    for (int l = 0; l < 7; l++) send_line(2 * W, 0);
    bus.CAM_vsync = 1'b1;
    repeat (12) @(negedge clk);
    chk("addr_in_saturated", 32'(bus.DP_RAM_addr_in), MAXA);
    chk("write_queue_drained", wq.size(), 0);
  endtask

  // pixel k of the raster is on the pins from clk edge 4k+8 after release
  task automatic vga_check(input int nlines);
    repeat (8) @(posedge clk);
    for (int k = 0; k < nlines * 800; k++) begin
      int          h, v;
      logic [11:0] e_rgb;
      logic        e_hs;
      h = k % 800;
      v = k / 800;
      @(negedge clk);
      e_hs  = !(h >= 656 && h <= 751);
      e_rgb = 12'd0;
      if (h < W && v < H && v > 0) e_rgb = exp_mem[v * W + h];
      if (h < W && v == 0)
        chk($sformatf("vga_sync h=%0d v=%0d", h, v),
            {bus.VGA_Hsync_n, bus.VGA_Vsync_n}, {e_hs, 1'b1});
      else
        chk($sformatf("vga_px h=%0d v=%0d", h, v),
            {bus.VGA_Hsync_n, bus.VGA_Vsync_n, bus.VGA_R, bus.VGA_G, bus.VGA_B},
            {e_hs, 1'b1, e_rgb});
      repeat (4) @(posedge clk);
    end
  endtask

  // write monitor: an increment of the write address marks a completed write
  initial begin : wr_mon
    logic [AW-1:0] prev_a;
    int            e;
    prev_a = '0;
    forever begin
      @(negedge clk);
      if (rst && (32'(bus.DP_RAM_addr_in) == 32'(prev_a) + 1)) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0h expected no write", prev_a);
        end else begin
          e = wq.pop_front();
          chk("write_addr", 32'(prev_a), e / 4096);
          chk("write_data", 32'(bus.DP_RAM_data_in), e % 4096);
        end
      end
      prev_a = bus.DP_RAM_addr_in;
    end
  end

  initial begin
    bus.CAM_pclk    = 1'b0;
    bus.CAM_vsync   = 1'b1;
    bus.CAM_href    = 1'b0;
    bus.CAM_px_data = 8'h00;
    rst             = 1'b0;
    repeat (20) @(negedge clk);

    chk("rst_hsync",    32'(bus.VGA_Hsync_n), 1);
    chk("rst_vsync",    32'(bus.VGA_Vsync_n), 1);
    chk("rst_rgb",      {bus.VGA_R, bus.VGA_G, bus.VGA_B}, 0);
    chk("rst_addr_in",  32'(bus.DP_RAM_addr_in), 0);
    chk("rst_data_in",  32'(bus.DP_RAM_data_in), 0);
    chk("rst_addr_out", 32'(bus.DP_RAM_addr_out), 0);
    chk("rst_data_mem", 32'(bus.data_mem), 0);
    chk("rst_xclk",     32'(bus.CAM_xclk), 0);
    chk("cam_pwdn",     32'(bus.CAM_pwdn), 0);
    chk("cam_reset",    32'(bus.CAM_reset), 1);

    rst = 1'b1;
    fork
      begin
        for (int n = 1; n <= 12; n++) begin
          @(negedge clk);
          chk($sformatf("xclk n=%0d", n), 32'(bus.CAM_xclk), ((n % 4) >= 2) ? 1 : 0);
        end
      end
      capture();
      vga_check(10);
    join

    // start a new frame, then reset in the middle of a pixel
    @(negedge clk); bus.CAM_vsync = 1'b0;
    repeat (8) @(negedge clk);
    bus.CAM_href = 1'b1;
    send_byte(8'hFF);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst2_addr_in", 32'(bus.DP_RAM_addr_in), 0);
    chk("rst2_data_in", 32'(bus.DP_RAM_data_in), 0);
    chk("rst2_hsync",   32'(bus.VGA_Hsync_n), 1);
    chk("rst2_data_mem", 32'(bus.data_mem), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("buffer_kept_addr0", 32'(bus.data_mem), 32'(exp_mem[0]));
    // no vsync fall after reset: these bytes must not be written
    for (int i = 0; i < 6; i++) send_byte(8'hFF);
    bus.CAM_href = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_addr_in", 32'(bus.DP_RAM_addr_in), 0);
    chk("abort_data_in", 32'(bus.DP_RAM_data_in), 0);
    chk("final_queue_empty", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
